// File: rtl/spi_slave_byte_if.sv
// Bundle of SPI pins plus the host-side TX/RX handshakes of spi_slave_byte.
// The slave modport is the responder's view; master is the link partner / host view.
interface spi_slave_byte_if;
  logic       sck_i;
  logic       ss_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ack_i;
  logic       overrun_o;
  logic       underrun_o;
  logic       clr_err_i;
  logic       busy_o;

  modport slave (
    input  sck_i, ss_i, mosi_i, tx_data_i, tx_valid_i, rx_ack_i, clr_err_i,
    output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           overrun_o, underrun_o, busy_o
  );

  modport master (
    output sck_i, ss_i, mosi_i, tx_data_i, tx_valid_i, rx_ack_i, clr_err_i,
    input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           overrun_o, underrun_o, busy_o
  );
endinterface

// File: rtl/spi_slave_byte.sv
// Oversampling SPI responder: byte-wide TX holding register and RX data register,
// all SPI pins synchronised into clk_i, any CPOL/CPHA mode.
module spi_slave_byte #(
  parameter bit         CPOL        = 1'b0,
  parameter bit         CPHA        = 1'b0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL        = 8'hFF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spi_slave_byte_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, ss_sync_reg, mosi_sync_reg;
  logic       sck_prev_reg;
  logic [2:0] cnt_reg;
  logic [7:0] shift_rx_reg, shift_tx_reg;
  logic       done_reg;
  logic       fill_pending_reg;
  logic       miso_reg;
  logic [7:0] hold_reg;
  logic       hold_full_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       overrun_reg, underrun_reg;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic load_en, sample_en, shift_en, byte_done;
  logic [7:0] tx_word;

  // Sync flops come out of reset at the bus idle levels so no false edge is seen.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_sync_reg  <= {SYNC_STAGES{CPOL}};
      ss_sync_reg   <= {SYNC_STAGES{1'b1}};
      mosi_sync_reg <= '0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0],  bus.sck_i};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0],   bus.ss_i};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.mosi_i};
    end
  end

  assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
  assign ss_s   = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_prev_reg;
  assign sck_fall    = ~sck_s & sck_prev_reg;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  assign tx_word   = hold_full_reg ? hold_reg : FILL;
  assign byte_done = sample_en && (cnt_reg == 3'd7);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // In CPHA=0 the trailing edge after the 8th sample is the end of the byte,
  // not a shift: MSB of the next byte is already on miso from LOAD.
  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!ss_s) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_en    = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        sample_en = sample_edge;
        shift_en  = shift_edge && (CPHA || (cnt_reg != 3'd0));
        if (sample_edge && (cnt_reg == 3'd7)) state_next = ST_LOAD;
      end
      default: state_next = ST_IDLE;
    endcase
    if (ss_s) begin
      state_next = ST_IDLE;
      load_en    = 1'b0;
      sample_en  = 1'b0;
      shift_en   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_prev_reg     <= CPOL;
      cnt_reg          <= '0;
      shift_rx_reg     <= '0;
      shift_tx_reg     <= '0;
      done_reg         <= 1'b0;
      fill_pending_reg <= 1'b0;
      miso_reg         <= 1'b0;
      hold_reg         <= '0;
      hold_full_reg    <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      overrun_reg      <= 1'b0;
      underrun_reg     <= 1'b0;
    end else begin
      sck_prev_reg <= sck_s;
      done_reg     <= byte_done;

      if (ss_s)           cnt_reg <= '0;
      else if (sample_en) cnt_reg <= cnt_reg + 3'd1;

      if (sample_en) shift_rx_reg <= {shift_rx_reg[6:0], mosi_s};

      if (load_en) begin
        shift_tx_reg     <= tx_word;
        fill_pending_reg <= !hold_full_reg;
        if (!CPHA) miso_reg <= tx_word[7];
      end else if (shift_en) begin
        miso_reg     <= CPHA ? shift_tx_reg[7] : shift_tx_reg[6];
        shift_tx_reg <= {shift_tx_reg[6:0], 1'b0};
      end

      // LOAD looks at the registered full flag, so a same-cycle write lands for the next byte.
      if (bus.tx_valid_i && !hold_full_reg) begin
        hold_reg      <= bus.tx_data_i;
        hold_full_reg <= 1'b1;
      end else if (load_en) begin
        hold_full_reg <= 1'b0;
      end

      if (done_reg) begin
        rx_data_reg  <= shift_rx_reg;
        rx_valid_reg <= 1'b1;
      end else if (bus.rx_ack_i) begin
        rx_valid_reg <= 1'b0;
      end

      if (done_reg && rx_valid_reg && !bus.rx_ack_i) overrun_reg <= 1'b1;
      else if (bus.clr_err_i)                          overrun_reg <= 1'b0;

      // FILL only counts as an underrun once the master actually clocks that byte,
      // so the speculative LOAD at the end of a transfer raises no error.
      if (sample_en && (cnt_reg == 3'd0) && fill_pending_reg) underrun_reg <= 1'b1;
      else if (bus.clr_err_i)                                 underrun_reg <= 1'b0;
    end
  end

  assign bus.miso_o     = miso_reg;
  assign bus.miso_oe_o  = ~ss_s;
  assign bus.busy_o     = ~ss_s;
  assign bus.tx_ready_o = ~hold_full_reg;
  assign bus.rx_data_o  = rx_data_reg;
  assign bus.rx_valid_o = rx_valid_reg;
  assign bus.overrun_o  = overrun_reg;
  assign bus.underrun_o = underrun_reg;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: bit-banged SPI master driving a mode-0
// instance and a CPOL=1/CPHA=1 instance.
module tb_spi_slave_byte;

  localparam int H = 8;  // sck half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_byte_if bus0 ();
  spi_slave_byte_if bus1 ();

  spi_slave_byte #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .FILL(8'hFF)) dut0 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus0)
  );

  spi_slave_byte #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2), .FILL(8'hFF)) dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  int checks = 0;
  int failures = 0;

  logic rxv_prev = 1'b0;
  int   rx_rises = 0;
  always @(posedge clk) begin
    rxv_prev <= bus0.rx_valid_o;
    if (bus0.rx_valid_o && !rxv_prev) rx_rises <= rx_rises + 1;
  end

  typedef struct {
    logic       pre_v;
    logic [7:0] pre_d;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic       exp_under;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sck(input int inst, input logic v);
    if (inst == 0) bus0.sck_i = v; else bus1.sck_i = v;
  endtask

  task automatic set_ss(input int inst, input logic v);
    if (inst == 0) bus0.ss_i = v; else bus1.ss_i = v;
  endtask

  task automatic set_mosi(input int inst, input logic v);
    if (inst == 0) bus0.mosi_i = v; else bus1.mosi_i = v;
  endtask

  function automatic logic get_miso(input int inst);
    return (inst == 0) ? bus0.miso_o : bus1.miso_o;
  endfunction

  task automatic write_tx(input int inst, input logic [7:0] d);
    if (inst == 0) begin
      check("tx_ready_before_write", bus0.tx_ready_o, 1);
      bus0.tx_data_i = d; bus0.tx_valid_i = 1'b1;
      wait_clks(1);
      bus0.tx_valid_i = 1'b0;
    end else begin
      check("tx_ready_before_write_m3", bus1.tx_ready_o, 1);
      bus1.tx_data_i = d; bus1.tx_valid_i = 1'b1;
      wait_clks(1);
      bus1.tx_valid_i = 1'b0;
    end
  endtask

  task automatic ack0();
    bus0.rx_ack_i = 1'b1; wait_clks(1); bus0.rx_ack_i = 1'b0;
  endtask

  task automatic clr0();
    bus0.clr_err_i = 1'b1; wait_clks(1); bus0.clr_err_i = 1'b0;
  endtask

  task automatic ss_low(input int inst);
    set_ss(inst, 1'b0);
    wait_clks(10);
  endtask

  task automatic ss_high(input int inst);
    wait_clks(H);
    set_ss(inst, 1'b1);
    wait_clks(8);
  endtask

  task automatic xfer(input int inst, input logic [7:0] mo, output logic [7:0] mi);
    logic cpol, cpha;
    cpol = (inst == 1);
    cpha = (inst == 1);
    mi = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!cpha) begin
        set_mosi(inst, mo[i]);
        wait_clks(H);
        mi[i] = get_miso(inst);
        set_sck(inst, ~cpol);
        wait_clks(H);
        set_sck(inst, cpol);
      end else begin
        set_sck(inst, ~cpol);
        set_mosi(inst, mo[i]);
        wait_clks(H);
        mi[i] = get_miso(inst);
        set_sck(inst, cpol);
        wait_clks(H);
      end
    end
    $display("xfer inst=%0d mosi=%02h miso=%02h", inst, mo, mi);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_miso"},     bus0.miso_o, 0);
    check({tag, "_miso_oe"},  bus0.miso_oe_o, 0);
    check({tag, "_tx_ready"}, bus0.tx_ready_o, 1);
    check({tag, "_rx_data"},  bus0.rx_data_o, 0);
    check({tag, "_rx_valid"}, bus0.rx_valid_o, 0);
    check({tag, "_overrun"},  bus0.overrun_o, 0);
    check({tag, "_underrun"}, bus0.underrun_o, 0);
    check({tag, "_busy"},     bus0.busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int rises_before;

    vecs[0] = '{pre_v: 1'b1, pre_d: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_under: 1'b0};
    vecs[1] = '{pre_v: 1'b0, pre_d: 8'h00, mosi: 8'h00, exp_miso: 8'hFF, exp_under: 1'b1};
    vecs[2] = '{pre_v: 1'b1, pre_d: 8'h81, mosi: 8'h7E, exp_miso: 8'h81, exp_under: 1'b0};
    vecs[3] = '{pre_v: 1'b1, pre_d: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_under: 1'b0};

    bus0.sck_i = 1'b0; bus0.ss_i = 1'b1; bus0.mosi_i = 1'b0;
    bus0.tx_data_i = '0; bus0.tx_valid_i = 1'b0; bus0.rx_ack_i = 1'b0; bus0.clr_err_i = 1'b0;
    bus1.sck_i = 1'b1; bus1.ss_i = 1'b1; bus1.mosi_i = 1'b0;
    bus1.tx_data_i = '0; bus1.tx_valid_i = 1'b0; bus1.rx_ack_i = 1'b0; bus1.clr_err_i = 1'b0;

    wait_clks(3);
    check_reset0("reset");
    check("reset_m3_tx_ready", bus1.tx_ready_o, 1);
    rst_n = 1'b1;
    wait_clks(4);

    // Single-byte transfers, each in its own selection.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].pre_v) write_tx(0, vecs[i].pre_d);
      ss_low(0);
      check($sformatf("v%0d_busy", i), bus0.busy_o, 1);
      xfer(0, vecs[i].mosi, got);
      ss_high(0);
      check($sformatf("v%0d_miso", i), got, vecs[i].exp_miso);
      check($sformatf("v%0d_rx_data", i), bus0.rx_data_o, vecs[i].mosi);
      check($sformatf("v%0d_rx_valid", i), bus0.rx_valid_o, 1);
      check($sformatf("v%0d_underrun", i), bus0.underrun_o, vecs[i].exp_under);
      check($sformatf("v%0d_overrun", i), bus0.overrun_o, 0);
      check($sformatf("v%0d_tx_ready", i), bus0.tx_ready_o, 1);
      ack0();
      clr0();
      wait_clks(1);
      check($sformatf("v%0d_rx_valid_acked", i), bus0.rx_valid_o, 0);
      check($sformatf("v%0d_underrun_cleared", i), bus0.underrun_o, 0);
    end

    // Back-to-back bytes with the holding register refilled mid-transfer.
    write_tx(0, 8'h81);
    ss_low(0);
    write_tx(0, 8'h42);
    xfer(0, 8'h11, got);
    check("b2b_miso0", got, 8'h81);
    check("b2b_rx0", bus0.rx_data_o, 8'h11);
    check("b2b_rx_valid0", bus0.rx_valid_o, 1);
    ack0();
    xfer(0, 8'h22, got);
    ss_high(0);
    check("b2b_miso1", got, 8'h42);
    check("b2b_rx1", bus0.rx_data_o, 8'h22);
    check("b2b_rx_valid1", bus0.rx_valid_o, 1);
    check("b2b_overrun", bus0.overrun_o, 0);
    check("b2b_underrun", bus0.underrun_o, 0);
    ack0();

    // Two bytes without acknowledging the first.
    ss_low(0);
    xfer(0, 8'h5A, got);
    xfer(0, 8'h96, got);
    ss_high(0);
    check("ovr_rx_data", bus0.rx_data_o, 8'h96);
    check("ovr_overrun", bus0.overrun_o, 1);
    check("ovr_underrun", bus0.underrun_o, 1);
    clr0();
    check("ovr_overrun_cleared", bus0.overrun_o, 0);
    check("ovr_rx_valid_kept", bus0.rx_valid_o, 1);
    ack0();

    // Abort after three sck edges, then a clean byte.
    rises_before = rx_rises;
    ss_low(0);
    set_mosi(0, 1'b1); wait_clks(H);
    set_sck(0, 1'b1);  wait_clks(H);
    set_sck(0, 1'b0);  set_mosi(0, 1'b0); wait_clks(H);
    set_sck(0, 1'b1);  wait_clks(H);
    set_ss(0, 1'b1);   wait_clks(H);
    set_sck(0, 1'b0);  wait_clks(8);
    $display("xfer inst=0 aborted after 3 edges");
    check("abort_rx_valid", bus0.rx_valid_o, 0);
    check("abort_overrun", bus0.overrun_o, 0);
    check("abort_busy", bus0.busy_o, 0);
    check("abort_miso_oe", bus0.miso_oe_o, 0);
    clr0();
    write_tx(0, 8'h3C);
    ss_low(0);
    xfer(0, 8'hC3, got);
    ss_high(0);
    check("abort_next_miso", got, 8'h3C);
    check("abort_next_rx", bus0.rx_data_o, 8'hC3);
    check("abort_next_rx_valid", bus0.rx_valid_o, 1);
    check("abort_next_overrun", bus0.overrun_o, 0);
    check("abort_next_underrun", bus0.underrun_o, 0);
    check("abort_single_valid", rx_rises - rises_before, 1);

    // Reset in the middle of a byte (C3 still unread, holding full, underrun set).
    ss_low(0);
    write_tx(0, 8'h77);
    set_mosi(0, 1'b1); wait_clks(H);
    set_sck(0, 1'b1);  wait_clks(H);
    set_sck(0, 1'b0);  wait_clks(2);
    check("prerst_tx_ready", bus0.tx_ready_o, 0);
    check("prerst_underrun", bus0.underrun_o, 1);
    check("prerst_busy", bus0.busy_o, 1);
    check("prerst_rx_valid", bus0.rx_valid_o, 1);
    rst_n = 1'b0;
    wait_clks(1);
    $display("xfer inst=0 reset mid-byte");
    check_reset0("midrst");
    set_ss(0, 1'b1); set_mosi(0, 1'b0); set_sck(0, 1'b0);
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(4);

    // CPOL=1 / CPHA=1 instance repeats the basic exchange.
    write_tx(1, 8'hA5);
    ss_low(1);
    xfer(1, 8'h3C, got);
    ss_high(1);
    check("m3_miso", got, 8'hA5);
    check("m3_rx_data", bus1.rx_data_o, 8'h3C);
    check("m3_rx_valid", bus1.rx_valid_o, 1);
    check("m3_underrun", bus1.underrun_o, 0);
    check("m3_overrun", bus1.overrun_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
